shift_cmd_sequencer: RTL
========================

# shift_cmd_sequencer

Command sequencer directly upstream of the 8-bit shift counter. Accepts shift commands over a valid/ready handshake, buffers one pending command, and drives the counter's `load`, `i` and `control` inputs cycle by cycle. After each command it captures the counter's `q` as a result. This turns the counter from a bench-driven block into a command-driven datapath stage.

## Interface
- `WIDTH`, 8: data width; matches the counter's `i` and `q`.
- `CNT_W`, 4: width of the run-length field; a command runs at most 2^CNT_W−1 cycles.
- `IDLE_CTRL`, 2'b00: value driven on `control` when no RUN is active.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: a command can be accepted.
- `cmd_load` in 1: load `cmd_data` into the counter before running.
- `cmd_data` in WIDTH: value for the counter's `i`.
- `cmd_mode` in 2: control code, held during RUN and passed through opaquely.
- `cmd_len` in CNT_W: number of RUN cycles.
- `load` out 1: drives the counter's `load`.
- `i` out WIDTH: drives the counter's `i`.
- `control` out 2: drives the counter's `control`.
- `q_in` in WIDTH: the counter's `q`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse in the DONE state.
- `result` out WIDTH: `q_in` captured at the end of DONE.
- `result_valid` out 1: one-cycle pulse the cycle after DONE.

## Operation
- Handshake:
  - Accept on a rising edge with `cmd_valid && cmd_ready`.
  - `cmd_ready = !pend_full`.
  - The accepted fields {load, data, mode, len} are written into the one-deep pending buffer.
- Pop: in IDLE or DONE with `pend_full`, the pending command moves to the active registers at the edge and `pend_full` clears.
  - Next state is LOAD if `cmd_load`.
  - Otherwise RUN if len ≠ 0.
  - Otherwise DONE.
- Accept and pop never coincide, because accept requires an empty buffer and pop requires a full one.
- States:
  - IDLE: `load`=0, `control`=IDLE_CTRL. Goes to the pop target if `pend_full`, else stays.
  - LOAD (1 cycle): `load`=1, `i`=data, `control`=IDLE_CTRL. Next is RUN if len ≠ 0, else DONE.
  - RUN: `load`=0, `control`=mode. A down-counter is loaded with len on entry and decrements each cycle; exit to DONE after exactly len cycles.
  - DONE (1 cycle): `done`=1, `control`=IDLE_CTRL, `result` ← `q_in` at the closing edge. Next is the pop target if `pend_full`, else IDLE.
- `i` holds the last loaded data outside LOAD.
- A command with len=0 and no load goes IDLE→DONE. `result` then reports the unchanged counter value.
- Outputs `load`, `i`, `control`, `done` and `busy` are registered, with no combinational path from `cmd_*`. `cmd_ready` is a direct function of `pend_full`.

## Timing
- Reset values: `load`=0, `i`=0, `control`=IDLE_CTRL, `busy`=0, `done`=0, `result`=0, `result_valid`=0, `cmd_ready`=1, state=IDLE, pending buffer empty.
- Reset mid-command aborts immediately and drops both the active and pending commands. No `done` or `result_valid` is produced for them.
- Latency from accept edge E0 into an idle block:
  - E1: pop.
  - Cycle after E1: first LOAD (or RUN) cycle.
  - With load and len=N: LOAD is 1 cycle, RUN is N cycles, DONE is 1 cycle, and `result_valid` is asserted the cycle after DONE.
  - Total from E0 to `result_valid`: N+4 cycles.
- Back-to-back commands: the second command pops at the DONE edge, so there are no idle cycles between commands.
- `cmd_ready` rises the cycle after a pop.

## Structure
- Package `shift_seq_pkg`:
  - State enum {IDLE, LOAD, RUN, DONE}.
  - Command struct {load, data, mode, len}.
  - Default IDLE_CTRL constant.
- Sub-module `shift_cmd_buf`: one-deep command register with full flag, write on accept, clear on pop.
- The FSM and run counter live in the top module.

## Test plan
- Single command: load=1, data=8'b10010111, mode=2'b01, len=3.
  - Required: `load` high for exactly 1 cycle with `i`=8'h97, then `control`=01 for 3 cycles, then `done` pulse.
  - Required: `result` equals `q_in` sampled at the end of DONE, and `result_valid` arrives 7 cycles after accept.
- load=1, len=0 → LOAD then DONE, with no cycle where `control`≠IDLE_CTRL.
- load=0, len=0 → IDLE→DONE, `done` after 2 cycles, `result` equals the unchanged `q_in`.
- Two commands with `cmd_valid` held:
  - Required: the second is accepted while the first runs, `cmd_ready` is low while the buffer is full, and the second LOAD directly follows the first DONE.
- `rst` asserted in the 2nd RUN cycle of a len=5 command with another command pending:
  - Required next cycle: all outputs at reset values, no `done`, `cmd_ready`=1.
- `cmd_valid` low throughout → `busy`=0 and `control`=IDLE_CTRL indefinitely.

Source files
------------

// File: rtl/shift_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types and constants for the shift command sequencer.
//               Holds the FSM state encoding, the command record and the
//               default idle control code. Also provides the pop-target
//               decode used wherever a pending command is launched.
// Revision    : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

    localparam int         CMD_DATA_W        = 8;
    localparam int         CMD_LEN_W         = 4;
    localparam logic [1:0] IDLE_CTRL_DEFAULT = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One buffered command. Field widths track the default sequencer widths.
    typedef struct packed {
        logic                  load;
        logic [CMD_DATA_W-1:0] data;
        logic [1:0]            mode;
        logic [CMD_LEN_W-1:0]  len;
    } cmd_t;

    // First state entered when a command leaves the pending buffer.
    function automatic state_t pop_target(input cmd_t c);
        if (c.load) begin
            return ST_LOAD;
        end else if (c.len != '0) begin
            return ST_RUN;
        end else begin
            return ST_DONE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_cmd_sequencer_if
// Description : Command handshake bundle feeding the shift command sequencer.
//               master : command source (drives valid and command fields)
//               slave  : sequencer (drives ready)
//   cmd_valid / cmd_ready : valid/ready handshake
//   cmd_load  : load cmd_data into the counter before running
//   cmd_data  : counter load value
//   cmd_mode  : control code applied during RUN
//   cmd_len   : number of RUN cycles
// Revision    : 1.0  initial release
// ============================================================================
interface shift_cmd_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = CMD_DATA_W,
    parameter int CNT_W = CMD_LEN_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_load,
        output cmd_data,
        output cmd_mode,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_load,
        input  cmd_data,
        input  cmd_mode,
        input  cmd_len,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/shift_cmd_sequencer_buf.sv
`default_nettype none
// ============================================================================
// Module      : shift_cmd_buf
// Description : One-deep pending command register with a full flag.
//               Written on accept, cleared on pop. Write and clear never
//               coincide because accept needs an empty buffer and pop a full
//               one; write is still given priority for robustness.
//   clk, rst : clock and synchronous active-high reset
//   wr_en    : accept strobe, wr_cmd is captured
//   rd_en    : pop strobe, full flag clears
//   full     : buffer holds a command
//   cmd      : buffered command
// Revision    : 1.0  initial release
// ============================================================================
module shift_cmd_buf
    import shift_seq_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic wr_en,
    input  wire cmd_t wr_cmd,
    input  wire logic rd_en,
    output logic      full,
    output cmd_t      cmd
);

    logic r_full;
    cmd_t r_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_cmd  <= '0;
        end else if (wr_en) begin
            r_full <= 1'b1;
            r_cmd  <= wr_cmd;
        end else if (rd_en) begin
            r_full <= 1'b0;
        end
    end

    assign full = r_full;
    assign cmd  = r_cmd;

endmodule
`default_nettype wire

// File: rtl/shift_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_cmd_sequencer
// Description : Command sequencer in front of the 8-bit shift counter.
//               Accepts commands over a valid/ready bundle, buffers one, and
//               walks IDLE -> [LOAD] -> [RUN x len] -> DONE, driving the
//               counter's load/i/control. The counter's q is captured as the
//               result when DONE closes.
//   clk, rst     : clock and synchronous active-high reset
//   cmd          : command bundle (slave side)
//   load, i      : counter load strobe and load value
//   control      : counter control code
//   q_in         : counter output
//   busy, done   : FSM not idle / one-cycle DONE pulse
//   result       : q_in captured at the end of DONE
//   result_valid : one-cycle pulse the cycle after DONE
// Revision    : 1.0  initial release
// ============================================================================
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    // The command record in the package is sized by CMD_DATA_W/CMD_LEN_W;
    // WIDTH and CNT_W must stay equal to those.
    parameter int         WIDTH     = CMD_DATA_W,
    parameter int         CNT_W     = CMD_LEN_W,
    parameter logic [1:0] IDLE_CTRL = IDLE_CTRL_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    shift_cmd_sequencer_if.slave   cmd,
    output logic                   load,
    output logic [WIDTH-1:0]       i,
    output logic [1:0]             control,
    input  wire logic [WIDTH-1:0]  q_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   result_valid
);

    logic   w_pend_full;
    cmd_t   w_pend;
    cmd_t   w_wr_cmd;
    logic   w_accept;
    logic   w_pop;
    state_t w_next;
    logic [1:0] w_run_mode;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_load;
    logic [WIDTH-1:0] r_i;
    logic [1:0]       r_control;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;

    assign cmd.cmd_ready = !w_pend_full;
    assign w_accept      = cmd.cmd_valid && !w_pend_full;
    assign w_wr_cmd      = '{load: cmd.cmd_load, data: cmd.cmd_data,
                             mode: cmd.cmd_mode, len: cmd.cmd_len};
    assign w_pop         = w_pend_full && (r_state == ST_IDLE || r_state == ST_DONE);

    shift_cmd_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_accept),
        .wr_cmd (w_wr_cmd),
        .rd_en  (w_pop),
        .full   (w_pend_full),
        .cmd    (w_pend)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pend_full) w_next = pop_target(w_pend);
            // The run counter already holds len from the pop.
            ST_LOAD: w_next = (r_run_cnt != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (r_run_cnt == CNT_W'(1)) w_next = ST_DONE;
            ST_DONE: w_next = w_pend_full ? pop_target(w_pend) : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A RUN entered straight from a pop takes its mode from the buffer.
    assign w_run_mode = w_pop ? w_pend.mode : r_mode;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_mode         <= IDLE_CTRL;
            r_run_cnt      <= '0;
            r_load         <= 1'b0;
            r_i            <= '0;
            r_control      <= IDLE_CTRL;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_pop) begin
                r_mode    <= w_pend.mode;
                r_run_cnt <= w_pend.len;
            end else if (r_state == ST_RUN) begin
                r_run_cnt <= r_run_cnt - 1'b1;
            end

            if (w_pop && w_pend.load) begin
                r_i <= w_pend.data;
            end

            r_load    <= (w_next == ST_LOAD);
            r_control <= (w_next == ST_RUN) ? w_run_mode : IDLE_CTRL;
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_DONE);

            r_result_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_result <= q_in;
            end
        end
    end

    assign load         = r_load;
    assign i            = r_i;
    assign control      = r_control;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire
